// File: rtl/rgb_to_luma.sv
// Post-demosaic luma stage: sweeps the R/G/B frame memories in raster order and
// writes Y = (77R + 150G + 29B + K) >> 8 to the Y memory. Macro RGB2Y_ROUND_EN selects K=128 (round) vs K=0 (truncate).
module rgb_to_luma #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_rgb,
  output logic [ADDR_W-1:0] addr_rgb,
  input  logic [7:0]        rdata_r,
  input  logic [7:0]        rdata_g,
  input  logic [7:0]        rdata_b,
  output logic              wr_y,
  output logic [ADDR_W-1:0] addr_y,
  output logic [7:0]        wdata_y,
  output logic              busy,
  output logic              done
);

  localparam int                N    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
`ifdef RGB2Y_ROUND_EN
  localparam logic [15:0] K = 16'd128;
`else
  localparam logic [15:0] K = 16'd0;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Memory-latency stage: tags the cycle in which rdata_* belongs to m_a_q
  logic              m_v_q;
  logic [ADDR_W-1:0] m_a_q;

  // Product stage
  logic              p_v_q;
  logic [ADDR_W-1:0] p_a_q;
  logic [14:0]       pr_q;
  logic [15:0]       pg_q;
  logic [12:0]       pb_q;

  // Output stage
  logic              wr_q;
  logic [ADDR_W-1:0] ay_q;
  logic [7:0]        wd_q;

  logic [15:0]       sum;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (addr_q == LAST) state_d = DRAIN;
        else                addr_d  = addr_q + 1'b1;
      end
      // The output stage holds the final write once the earlier stages are empty
      DRAIN: begin
        if (!m_v_q && !p_v_q) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign sum = {1'b0, pr_q} + pg_q + {3'b000, pb_q} + K;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_v_q <= 1'b0;
      m_a_q <= '0;
      p_v_q <= 1'b0;
      p_a_q <= '0;
      pr_q  <= '0;
      pg_q  <= '0;
      pb_q  <= '0;
      wr_q  <= 1'b0;
      ay_q  <= '0;
      wd_q  <= '0;
    end else begin
      m_v_q <= rd_rgb;
      m_a_q <= addr_q;
      p_v_q <= m_v_q;
      p_a_q <= m_a_q;
      pr_q  <= 15'(rdata_r) * 15'd77;
      pg_q  <= 16'(rdata_g) * 16'd150;
      pb_q  <= 13'(rdata_b) * 13'd29;
      wr_q  <= p_v_q;
      if (p_v_q) begin
        ay_q <= p_a_q;
        wd_q <= sum[15:8];
      end
    end
  end

  assign rd_rgb   = (state_q == READ);
  assign addr_rgb = addr_q;
  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == FIN);
  assign wr_y     = wr_q;
  assign addr_y   = ay_q;
  assign wdata_y  = wd_q;

endmodule
